// File: rtl/collatz_nav_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : collatz_pkg                                                 |
// | Purpose    : Shared types and constants for the Collatz front-panel      |
// |              controller: navigation state encoding and key indices.      |
// | Ports      : none (package)                                             |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    BROWSE = 2'd3
  } nav_state_t;

  // Bit positions within the raw key_n bus
  localparam int KEY_NEXT  = 0;
  localparam int KEY_PREV  = 1;
  localparam int KEY_HOME  = 2;
  localparam int KEY_START = 3;
  localparam int NUM_KEYS  = 4;

endpackage
`default_nettype wire

// File: rtl/collatz_nav_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : collatz_nav_if                                              |
// | Purpose    : go/done handshake and data bus between the front-panel      |
// |              controller (master) and the range engine (slave).           |
// | Signals    : go    - start pulse to range                                |
// |              start - base while go, else {0,addr}                        |
// |              done  - range results valid                                 |
// |              count - iteration count at RAM[addr]                        |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface collatz_nav_if #(
  parameter int COUNT_BITS = 16
) ();

  logic                  go;
  logic [31:0]           start;
  logic                  done;
  logic [COUNT_BITS-1:0] count;

  modport master (output go, output start, input done, input count);
  modport slave  (input go, input start, output done, output count);

endinterface
`default_nettype wire

// File: rtl/collatz_nav_btn_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : btn_cond                                                    |
// | Purpose    : Conditions one raw active-low pushbutton: 2-FF sync,        |
// |              debounce, one-cycle press pulse and (optionally) a          |
// |              periodic auto-repeat pulse while held.                      |
// | Macro      : COLLATZ_NAV_AUTOREPEAT_EN enables the auto-repeat path.     |
// | Ports      : clk   in  system clock                                      |
// |              rst_n in  async active-low reset                            |
// |              key_n in  raw button, active low                            |
// |              step  out one-cycle pulse: accepted press or repeat step    |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module btn_cond #(
  parameter int DEBOUNCE_CYC = 500000
`ifdef COLLATZ_NAV_AUTOREPEAT_EN
  ,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
`endif
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic key_n,
  output logic      step
);

  localparam int                  c_cnt_w   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(DEBOUNCE_CYC);

  logic [1:0]         r_sync;
  logic               r_stable;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_press;
  logic               w_rep;

  // The stable level only changes after the synced input has disagreed with
  // it for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
        r_press  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

`ifdef COLLATZ_NAV_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int c_hold_w = $clog2(HOLD_CYC);
    logic [c_hold_w-1:0] r_hold;
    logic                r_rep;

    // r_hold counts cycles since the press; the first repeat fires HOLD_CYC
    // after the press, then the counter is rewound so that later repeats
    // come every REPEAT_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
        r_rep  <= 1'b0;
      end else begin
        r_rep <= 1'b0;
        if (r_stable) begin
          r_hold <= '0;
        end else if (r_hold == c_hold_w'(HOLD_CYC - 1)) begin
          r_rep  <= 1'b1;
          r_hold <= c_hold_w'(HOLD_CYC - REPEAT_CYC);
        end else begin
          r_hold <= r_hold + c_hold_w'(1);
        end
      end
    end
    assign w_rep = r_rep;
  end else begin : g_no_rep
    assign w_rep = 1'b0;
  end
`else
  assign w_rep = 1'b0;
`endif

  assign step = r_press | w_rep;

endmodule
`default_nettype wire

// File: rtl/collatz_nav.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : collatz_nav                                                 |
// | Purpose    : Front-panel controller for the Collatz range engine.        |
// |              Conditions buttons, sequences go/done, keeps the browse     |
// |              pointer and drives the n/count display fields.              |
// | Macro      : COLLATZ_NAV_AUTOREPEAT_EN adds auto-repeat on next/prev     |
// |              (and the HOLD_CYC / REPEAT_CYC parameters).                 |
// | Ports      : clk      in  system clock                                   |
// |              rst_n    in  async active-low reset                         |
// |              key_n    in  raw keys: [0]next [1]prev [2]home [3]start     |
// |              sw       in  base number for a run                          |
// |              bus      if  master side of go/start/done/count             |
// |              addr     out browse pointer                                 |
// |              n_disp   out base+addr (BROWSE only, else 0)                |
// |              cnt_disp out low DISP_BITS of count (BROWSE only, else 0)   |
// |              cnt_ovf  out count wider than display (BROWSE only)         |
// |              busy     out high in LAUNCH or RUN                          |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module collatz_nav
  import collatz_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int BASE_BITS    = 10,
  parameter int COUNT_BITS   = 16,
  parameter int DISP_BITS    = 12,
  parameter int DEBOUNCE_CYC = 500000,
`ifdef COLLATZ_NAV_AUTOREPEAT_EN
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000,
`endif
  parameter int WRAP         = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [NUM_KEYS-1:0]   key_n,
  input  wire logic [BASE_BITS-1:0]  sw,
  collatz_nav_if.master              bus,
  output logic [ADDR_BITS-1:0]       addr,
  output logic [DISP_BITS-1:0]       n_disp,
  output logic [DISP_BITS-1:0]       cnt_disp,
  output logic                       cnt_ovf,
  output logic                       busy
);

  localparam int c_sum_w = BASE_BITS + ADDR_BITS;

  nav_state_t           r_state, w_state_nx;
  logic [ADDR_BITS-1:0] r_addr, w_addr_nx, w_addr_inc, w_addr_dec;
  logic [BASE_BITS-1:0] r_base, w_base_nx;
  logic                 r_go, r_cnt_ovf, r_busy;
  logic [31:0]          r_start;
  logic [DISP_BITS-1:0] r_n_disp, r_cnt_disp, w_cnt_low;
  logic                 w_cnt_hi, w_browse_nx;
  logic [NUM_KEYS-1:0]  w_key_step;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    btn_cond #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef COLLATZ_NAV_AUTOREPEAT_EN
      ,
      .REPEAT_EN    (i == KEY_NEXT || i == KEY_PREV),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
`endif
    ) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n[i]),
      .step  (w_key_step[i])
    );
  end

  if (COUNT_BITS > DISP_BITS) begin : g_cnt_wide
    assign w_cnt_low = bus.count[DISP_BITS-1:0];
    assign w_cnt_hi  = |bus.count[COUNT_BITS-1:DISP_BITS];
  end else begin : g_cnt_narrow
    assign w_cnt_low = DISP_BITS'(bus.count);
    assign w_cnt_hi  = 1'b0;
  end

  // WRAP=0 holds the pointer at either end instead of rolling over
  assign w_addr_inc = (WRAP == 0 && r_addr == {ADDR_BITS{1'b1}}) ? r_addr
                                                                  : r_addr + ADDR_BITS'(1);
  assign w_addr_dec = (WRAP == 0 && r_addr == '0) ? r_addr : r_addr - ADDR_BITS'(1);

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_base_nx  = r_base;
    case (r_state)
      IDLE, BROWSE: begin
        if (w_key_step[KEY_START]) begin
          w_state_nx = LAUNCH;
          w_base_nx  = sw;
          w_addr_nx  = '0;
        end else if (r_state == BROWSE) begin
          // home beats next beats prev when pulses coincide
          if (w_key_step[KEY_HOME])      w_addr_nx = '0;
          else if (w_key_step[KEY_NEXT]) w_addr_nx = w_addr_inc;
          else if (w_key_step[KEY_PREV]) w_addr_nx = w_addr_dec;
        end
      end
      LAUNCH:  w_state_nx = RUN;
      RUN:     if (bus.done) w_state_nx = BROWSE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_browse_nx = (w_state_nx == BROWSE);

  // Outputs are registered from next-state values so they line up with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_base     <= '0;
      r_go       <= 1'b0;
      r_start    <= '0;
      r_n_disp   <= '0;
      r_cnt_disp <= '0;
      r_cnt_ovf  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_addr     <= w_addr_nx;
      r_base     <= w_base_nx;
      r_go       <= (w_state_nx == LAUNCH);
      r_start    <= (w_state_nx == LAUNCH) ? 32'(w_base_nx) : 32'(w_addr_nx);
      r_n_disp   <= w_browse_nx ? DISP_BITS'(c_sum_w'(w_base_nx) + c_sum_w'(w_addr_nx)) : '0;
      r_cnt_disp <= w_browse_nx ? w_cnt_low : '0;
      r_cnt_ovf  <= w_browse_nx & w_cnt_hi;
      r_busy     <= (w_state_nx == LAUNCH) || (w_state_nx == RUN);
    end
  end

  assign bus.go    = r_go;
  assign bus.start = r_start;
  assign addr      = r_addr;
  assign n_disp    = r_n_disp;
  assign cnt_disp  = r_cnt_disp;
  assign cnt_ovf   = r_cnt_ovf;
  assign busy      = r_busy;

endmodule
`default_nettype wire
